// File: rtl/interp_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | interp_pkg : shared constants and 16-phase 8-tap luma coefficient table |
// | Revision   : 1.0                                                        |
// +------------------------------------------------------------------------+
package interp_pkg;

  localparam int NUM_TAPS    = 8;
  localparam int NUM_PHASES  = 16;
  localparam int ROUND_OFS   = 32;
  localparam int ROUND_SHIFT = 6;
  localparam int COEF_W      = 8;

  // Row = phase (1/16 pel), column = tap applied to w0 (oldest) .. w7 (newest).
  localparam logic signed [COEF_W-1:0] COEF_TABLE [NUM_PHASES][NUM_TAPS] = '{
    '{ 8'sd0,  8'sd0,  8'sd0,   8'sd64, 8'sd0,   8'sd0,   8'sd0,  8'sd0 },
    '{ 8'sd0,  8'sd1, -8'sd3,   8'sd63, 8'sd4,  -8'sd2,   8'sd1,  8'sd0 },
    '{-8'sd1,  8'sd2, -8'sd5,   8'sd62, 8'sd8,  -8'sd3,   8'sd1,  8'sd0 },
    '{-8'sd1,  8'sd3, -8'sd8,   8'sd60, 8'sd13, -8'sd4,   8'sd1,  8'sd0 },
    '{-8'sd1,  8'sd4, -8'sd10,  8'sd58, 8'sd17, -8'sd5,   8'sd1,  8'sd0 },
    '{-8'sd1,  8'sd4, -8'sd11,  8'sd52, 8'sd26, -8'sd8,   8'sd3, -8'sd1 },
    '{-8'sd1,  8'sd3, -8'sd9,   8'sd47, 8'sd31, -8'sd10,  8'sd4, -8'sd1 },
    '{-8'sd1,  8'sd4, -8'sd11,  8'sd45, 8'sd34, -8'sd10,  8'sd4, -8'sd1 },
    '{-8'sd1,  8'sd4, -8'sd11,  8'sd40, 8'sd40, -8'sd11,  8'sd4, -8'sd1 },
    '{-8'sd1,  8'sd4, -8'sd10,  8'sd34, 8'sd45, -8'sd11,  8'sd4, -8'sd1 },
    '{-8'sd1,  8'sd4, -8'sd10,  8'sd31, 8'sd47, -8'sd9,   8'sd3, -8'sd1 },
    '{-8'sd1,  8'sd3, -8'sd8,   8'sd26, 8'sd52, -8'sd11,  8'sd4, -8'sd1 },
    '{ 8'sd0,  8'sd1, -8'sd5,   8'sd17, 8'sd58, -8'sd10,  8'sd4, -8'sd1 },
    '{ 8'sd0,  8'sd1, -8'sd4,   8'sd13, 8'sd60, -8'sd8,   8'sd3, -8'sd1 },
    '{ 8'sd0,  8'sd1, -8'sd3,   8'sd8,  8'sd62, -8'sd5,   8'sd2, -8'sd1 },
    '{ 8'sd0,  8'sd1, -8'sd2,   8'sd4,  8'sd63, -8'sd3,   8'sd1,  8'sd0 }
  };

  function automatic logic signed [COEF_W-1:0] coef(input logic [3:0] phase,
                                                     input logic [2:0] tap);
    return COEF_TABLE[phase][tap];
  endfunction

endpackage
`default_nettype wire

// File: rtl/interp_round_clip.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | interp_round_clip : (sum + 32) >>> 6, optional clip to sample range     |
// | Option     : INTERP_FRAC_FILTER_CLIP_EN enables clipping               |
// | Revision   : 1.0                                                        |
// +------------------------------------------------------------------------+
module interp_round_clip
  import interp_pkg::*;
#(
  parameter int SAMPLE_W = 8,
  parameter int ACC_W    = 20
) (
  input  logic signed [ACC_W-1:0] sum,
  output logic        [15:0]      result
);

  logic signed [ACC_W-1:0] rounded;

  assign rounded = (sum + ACC_W'(ROUND_OFS)) >>> ROUND_SHIFT;

`ifdef INTERP_FRAC_FILTER_CLIP_EN
  localparam logic signed [ACC_W-1:0] MAX_VAL = ACC_W'((1 << SAMPLE_W) - 1);

  logic [SAMPLE_W-1:0] clipped;

  always_comb begin
    clipped = rounded[SAMPLE_W-1:0];
    if (rounded[ACC_W-1]) begin
      clipped = '0;
    end else if (rounded > MAX_VAL) begin
      clipped = '1;
    end
  end

  assign result = 16'(clipped);
`else
  // Signed size cast: sign-extends when ACC_W < 16, truncates otherwise.
  assign result = 16'(rounded);
`endif

endmodule
`default_nettype wire

// File: rtl/interp_frac_filter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | interp_frac_filter : streaming 8-tap 1/16-pel row interpolator          |
// | Option     : INTERP_FRAC_FILTER_CLIP_EN (see interp_round_clip)         |
// | Revision   : 1.0                                                        |
// +------------------------------------------------------------------------+
module interp_frac_filter
  import interp_pkg::*;
#(
  parameter int SAMPLE_W = 8,
  parameter int ACC_W    = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SAMPLE_W-1:0] in_sample,
  input  logic                in_last,
  input  logic [3:0]          frac,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [15:0]         out_sample
);

  localparam int CNT_W = $clog2(NUM_TAPS + 1);

  logic [SAMPLE_W-1:0]     window_q [NUM_TAPS];
  logic [SAMPLE_W-1:0]     window_d [NUM_TAPS];
  logic [CNT_W-1:0]        count_q, count_d;
  logic [3:0]              phase_q, phase_d;
  logic signed [ACC_W-1:0] sum_q, sum_d;
  logic                    s1_valid_q, s1_valid_d;
  logic [15:0]             out_sample_q, out_sample_d;
  logic                    out_valid_q, out_valid_d;

  logic                    advance;
  logic                    accept;
  logic                    emit;
  logic signed [ACC_W-1:0] filt_sum;
  logic [15:0]             rc_result;

  // Whole pipeline moves together; a stalled output freezes every stage.
  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance;
  assign accept   = in_valid && advance;
  assign emit     = accept && (count_q >= CNT_W'(NUM_TAPS - 1));

  always_comb begin
    window_d = window_q;
    count_d  = count_q;
    phase_d  = phase_q;
    if (accept) begin
      for (int k = 0; k < NUM_TAPS - 1; k++) begin
        window_d[k] = window_q[k+1];
      end
      window_d[NUM_TAPS-1] = in_sample;
      if (count_q == '0) begin
        phase_d = frac;
      end
      if (in_last) begin
        count_d = '0;
      end else if (count_q != CNT_W'(NUM_TAPS)) begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  // Filter the window as it will look after this acceptance; phase_q is
  // already the row phase whenever emit can be high (count >= 7).
  always_comb begin
    filt_sum = '0;
    for (int k = 0; k < NUM_TAPS; k++) begin
      filt_sum = filt_sum + $signed(ACC_W'(window_d[k])) * ACC_W'(coef(phase_q, 3'(k)));
    end
  end

  always_comb begin
    sum_d        = sum_q;
    s1_valid_d   = s1_valid_q;
    out_valid_d  = out_valid_q;
    out_sample_d = out_sample_q;
    if (advance) begin
      s1_valid_d  = emit;
      out_valid_d = s1_valid_q;
      if (emit) begin
        sum_d = filt_sum;
      end
      if (s1_valid_q) begin
        out_sample_d = rc_result;
      end
    end
  end

  interp_round_clip #(
    .SAMPLE_W (SAMPLE_W),
    .ACC_W    (ACC_W)
  ) u_round_clip (
    .sum    (sum_q),
    .result (rc_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        window_q[k] <= '0;
      end
      count_q      <= '0;
      phase_q      <= '0;
      sum_q        <= '0;
      s1_valid_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_sample_q <= '0;
    end else begin
      window_q     <= window_d;
      count_q      <= count_d;
      phase_q      <= phase_d;
      sum_q        <= sum_d;
      s1_valid_q   <= s1_valid_d;
      out_valid_q  <= out_valid_d;
      out_sample_q <= out_sample_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_sample = out_sample_q;

endmodule
`default_nettype wire

// File: tb/tb_interp_frac_filter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_interp_frac_filter : directed self-checking bench                    |
// | Revision   : 1.0                                                        |
// +------------------------------------------------------------------------+
module tb_interp_frac_filter;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        in_valid  = 1'b0;
  logic        in_last   = 1'b0;
  logic        out_ready = 1'b1;
  logic [7:0]  in_sample = 8'd0;
  logic [3:0]  frac      = 4'd0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_sample;

  int n_cmp     = 0;
  int n_bad     = 0;
  int cyc       = 0;
  int acc_total = 0;

  logic [15:0] out_vals [$];
  int          out_cycs [$];
  int          acc_cycs [$];

`ifdef INTERP_FRAC_FILTER_CLIP_EN
  localparam logic [15:0] EXP_PEAK   = 16'd255;
  localparam logic [15:0] EXP_TROUGH = 16'd0;
`else
  localparam logic [15:0] EXP_PEAK   = 16'd319;
  localparam logic [15:0] EXP_TROUGH = 16'hFFC0;
`endif

  always #5 clk = ~clk;

  interp_frac_filter #(
    .SAMPLE_W (8),
    .ACC_W    (20)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sample  (in_sample),
    .in_last    (in_last),
    .frac       (frac),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sample (out_sample)
  );

  always @(posedge clk) begin
    if (in_valid && in_ready) begin
      acc_cycs.push_back(cyc);
      acc_total <= acc_total + 1;
    end
    if (out_valid && out_ready) begin
      out_vals.push_back(out_sample);
      out_cycs.push_back(cyc);
    end
    cyc <= cyc + 1;
  end

  task automatic clear_log();
    out_vals.delete();
    out_cycs.delete();
    acc_cycs.delete();
  endtask

  task automatic drain();
    repeat (8) @(negedge clk);
  endtask

  // Offers one sample; in_ready is sampled 2 time units after the falling edge.
  task automatic send(input logic [7:0] s, input logic last, input logic [3:0] f);
    int tries;
    @(negedge clk);
    in_valid  = 1'b1;
    in_sample = s;
    in_last   = last;
    frac      = f;
    #2;
    tries = 0;
    while (!in_ready && tries < 50) begin
      @(negedge clk);
      #2;
      tries++;
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_out_valid: got %b required 0", out_valid);
    end
    n_cmp++;
    if (out_sample !== 16'd0) begin
      n_bad++; $display("FAIL reset_out_sample: got %0d required 0", out_sample);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL post_reset_out_valid: got %b required 0", out_valid);
    end
  endtask

  task automatic test_flat_row();
    clear_log();
    for (int i = 0; i < 12; i++) send(8'd100, i == 11, 4'd8);
    drain();
    n_cmp++;
    if (out_vals.size() != 5) begin
      n_bad++; $display("FAIL flat_count: got %0d required 5", out_vals.size());
    end
    foreach (out_vals[i]) begin
      n_cmp++;
      if (out_vals[i] !== 16'd100) begin
        n_bad++; $display("FAIL flat_value[%0d]: got %0d required 100", i, out_vals[i]);
      end
    end
    if (out_cycs.size() > 0 && acc_cycs.size() >= 8) begin
      n_cmp++;
      if (out_cycs[0] - acc_cycs[7] != 2) begin
        n_bad++; $display("FAIL flat_latency: got %0d required 2", out_cycs[0] - acc_cycs[7]);
      end
    end
    if (out_cycs.size() == 5) begin
      n_cmp++;
      if (out_cycs[4] - out_cycs[0] != 4) begin
        n_bad++; $display("FAIL flat_back_to_back: span %0d required 4", out_cycs[4] - out_cycs[0]);
      end
    end
  endtask

  task automatic test_short_row();
    clear_log();
    for (int i = 0; i < 5; i++) send(8'd50, i == 4, 4'd0);
    drain();
    n_cmp++;
    if (out_vals.size() != 0) begin
      n_bad++; $display("FAIL short_row_count: got %0d required 0", out_vals.size());
    end
  endtask

  // frac changes after the first sample must be ignored (phase 0 kept).
  task automatic test_ramp();
    logic [15:0] exp_v;
    clear_log();
    for (int i = 0; i < 10; i++) send(8'(i), i == 9, (i == 0) ? 4'd0 : 4'd8);
    drain();
    n_cmp++;
    if (out_vals.size() != 3) begin
      n_bad++; $display("FAIL ramp_count: got %0d required 3", out_vals.size());
    end
    foreach (out_vals[i]) begin
      exp_v = 16'(i + 3);
      n_cmp++;
      if (out_vals[i] !== exp_v) begin
        n_bad++; $display("FAIL ramp_value[%0d]: got %0d required %0d", i, out_vals[i], exp_v);
      end
    end
  endtask

  task automatic test_peak_trough();
    logic [7:0] v;
    clear_log();
    for (int i = 0; i < 8; i++) begin
      v = (i == 3 || i == 4) ? 8'd255 : 8'd0;
      send(v, i == 7, 4'd8);
    end
    drain();
    n_cmp++;
    if (out_vals.size() != 1) begin
      n_bad++; $display("FAIL peak_count: got %0d required 1", out_vals.size());
    end else begin
      n_cmp++;
      if (out_vals[0] !== EXP_PEAK) begin
        n_bad++; $display("FAIL peak_value: got %h required %h", out_vals[0], EXP_PEAK);
      end
    end
    clear_log();
    for (int i = 0; i < 8; i++) begin
      v = (i == 3 || i == 4) ? 8'd0 : 8'd255;
      send(v, i == 7, 4'd8);
    end
    drain();
    n_cmp++;
    if (out_vals.size() != 1) begin
      n_bad++; $display("FAIL trough_count: got %0d required 1", out_vals.size());
    end else begin
      n_cmp++;
      if (out_vals[0] !== EXP_TROUGH) begin
        n_bad++; $display("FAIL trough_value: got %h required %h", out_vals[0], EXP_TROUGH);
      end
    end
  endtask

  // Stall begins while the last sample is pending, so its acceptance
  // coincides with the stalled output draining.
  task automatic test_stall();
    int          base;
    logic [15:0] held;
    logic [15:0] exp_v;
    clear_log();
    base = acc_total;
    fork
      begin
        for (int i = 0; i < 12; i++) send(8'((i + 1) * 10), i == 11, 4'd0);
      end
      begin
        int tries;
        tries = 0;
        while (acc_total < base + 11 && tries < 200) begin
          @(negedge clk);
          tries++;
        end
        out_ready = 1'b0;
        #1;
        held = out_sample;
        n_cmp++;
        if (out_valid !== 1'b1) begin
          n_bad++; $display("FAIL stall_out_valid: got %b required 1", out_valid);
        end
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          #1;
          n_cmp++;
          if (in_ready !== 1'b0) begin
            n_bad++; $display("FAIL stall_in_ready[%0d]: got %b required 0", c, in_ready);
          end
          n_cmp++;
          if (out_sample !== held) begin
            n_bad++; $display("FAIL stall_hold[%0d]: got %0d required %0d", c, out_sample, held);
          end
        end
        out_ready = 1'b1;
      end
    join
    drain();
    n_cmp++;
    if (out_vals.size() != 5) begin
      n_bad++; $display("FAIL stall_count: got %0d required 5", out_vals.size());
    end
    foreach (out_vals[i]) begin
      exp_v = 16'((i + 4) * 10);
      n_cmp++;
      if (out_vals[i] !== exp_v) begin
        n_bad++; $display("FAIL stall_value[%0d]: got %0d required %0d", i, out_vals[i], exp_v);
      end
    end
  endtask

  task automatic test_reset_mid_row();
    for (int i = 0; i < 5; i++) send(8'd200, 1'b0, 4'd8);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL midreset_out_valid: got %b required 0", out_valid);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_log();
    for (int i = 0; i < 8; i++) send(8'((i + 1) * 10), i == 7, (i == 0) ? 4'd4 : 4'd0);
    drain();
    n_cmp++;
    if (out_vals.size() != 1) begin
      n_bad++; $display("FAIL midreset_count: got %0d required 1", out_vals.size());
    end else begin
      n_cmp++;
      if (out_vals[0] !== 16'd42) begin
        n_bad++; $display("FAIL midreset_phase4: got %0d required 42", out_vals[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_flat_row();
    test_short_row();
    test_ramp();
    test_peak_trough();
    test_stall();
    test_reset_mid_row();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/interp_frac_filter.md
INTERP_FRAC_FILTER -- requirements
Module: interp_frac_filter

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 8, meaning input sample width in bits (unsigned).
REQ-002 SHALL have parameter ACC_W, default 20, meaning signed accumulator width in bits.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  in_sample, in_last and frac are valid.
REQ-006 SHALL have port in_ready  output  1  block accepts input this cycle.
REQ-007 SHALL have port in_sample  input  SAMPLE_W  integer-position pixel.
REQ-008 SHALL have port in_last  input  1  in_sample is the final sample of the row.
REQ-009 SHALL have port frac  input  4  1/16 phase (0..15), sampled on the first sample of each row.
REQ-010 SHALL have port out_valid  output  1  out_sample holds an interpolated result.
REQ-011 SHALL have port out_ready  input  1  downstream accepts out_sample.
REQ-012 SHALL have port out_sample  output  16  signed interpolated sample.

Function
REQ-013 SHALL accept an input when in_valid and in_ready are both high, and SHALL drive in_ready = !out_valid || out_ready.
REQ-014 SHALL shift each accepted sample into an 8-entry window (w0 oldest .. w7 newest) and count samples per row, saturating at 8.
REQ-015 SHALL latch frac into a row phase register when an accepted sample has count==0, and SHALL ignore frac at all other times.
REQ-016 SHALL compute sum = Σ c[phase][k]·wk with the 8-tap 1/16 luma table (phase 8 = {-1,4,-11,40,40,-11,4,-1}; tap 3 across phases 1..15 = 63,62,60,58,52,47,45,40,34,31,26,17,13,8,4; phase 0 = 64 at tap 3, 0 elsewhere).
REQ-017 SHALL compute the result as (sum + 32) >>> 6, arithmetic shift, in ACC_W bits with no overflow.
REQ-018 SHALL produce one output per accepted sample once the count has reached 8, so a row of N≥8 samples yields N-7 outputs and a row of N<8 samples yields none.
REQ-019 SHALL use a two-stage pipeline (products/sum, then round/clip): out_valid rises 2 cycles after the acceptance of the window-completing sample, without stall.
REQ-020 SHALL hold all pipeline registers and out_sample stable while out_valid && !out_ready (full stall).
REQ-021 SHALL clear the count to 0 after accepting a sample with in_last, and the output for that sample (if any) SHALL still be emitted.
REQ-022 SHALL, when in_last is accepted in the same cycle as a stalled output drains, complete both without dropping or duplicating data.

Reset
REQ-023 SHALL, while rst_n is low, asynchronously force out_valid=0, out_sample=0, count=0, phase=0, window=0 and pipeline valids=0.
REQ-024 SHALL, when reset asserts mid-row, discard in-flight results, and the first accepted sample after release SHALL start a new row.

Configuration
REQ-025 SHALL, when INTERP_FRAC_FILTER_CLIP_EN is defined, clip the rounded result to [0, 2^SAMPLE_W-1] and zero-extend it onto out_sample.
REQ-026 SHALL, when INTERP_FRAC_FILTER_CLIP_EN is undefined, output the rounded result unclipped, sign-extended or truncated to 16 bits.

Structure
REQ-027 SHALL take the coefficient table (16x8 signed 8-bit), the rounding constant 32, the shift 6 and the tap count 8 from a shared package interp_pkg.
REQ-028 SHALL instantiate one sub-module, interp_round_clip, implementing REQ-017/025/026 as a combinational function between pipeline stages.

Verification
REQ-029 The bench SHALL cover: row of 12 samples all 100, frac=8 -> exactly 5 outputs, each 100, first at 2 cycles after the 8th acceptance.
REQ-030 The bench SHALL cover: ramp 0,1,..,9, frac=0 -> outputs 3,4,5 (tap-3 passthrough).
REQ-031 The bench SHALL cover: window {0,0,0,255,255,0,0,0}, frac=8 -> 255 with CLIP_EN, 319 without.
REQ-032 The bench SHALL cover: window {255,255,255,0,0,255,255,255}, frac=8 -> 0 with CLIP_EN, -64 without.
REQ-033 The bench SHALL cover: out_ready low for 5 cycles mid-row -> in_ready low, out_sample stable, no loss or duplication after release.
REQ-034 The bench SHALL cover: rst_n pulsed after 5 samples, then 8 new samples with frac=4 -> no stale output, one output using phase 4.
